// File: rtl/rename_map_stage_if.sv
// Bundle-level connection of the rename stage: decode input, free-list pop,
// renamed output to dispatch/ROB, and the commit port that updates the
// retirement alias table.
interface rename_map_stage_if #(
    parameter int L_REGISTERS = 32,
    parameter int P_REGISTERS = 128,
    parameter int INSTR_COUNT = 2,
    parameter int LW          = $clog2(L_REGISTERS),
    parameter int PW          = $clog2(P_REGISTERS)
);
    logic                            flush;

    logic                            in_valid;
    logic                            in_ready;
    logic [INSTR_COUNT-1:0]          in_lane_valid;
    logic [INSTR_COUNT-1:0][LW-1:0]  in_src1;
    logic [INSTR_COUNT-1:0][LW-1:0]  in_src2;
    logic [INSTR_COUNT-1:0][LW-1:0]  in_dst;
    logic [INSTR_COUNT-1:0]          in_dst_en;

    logic [INSTR_COUNT-1:0][PW-1:0]  fl_pop_data;
    logic                            fl_valid;
    logic                            fl_pop;

    logic                            out_valid;
    logic                            out_ready;
    logic [INSTR_COUNT-1:0]          out_lane_valid;
    logic [INSTR_COUNT-1:0][PW-1:0]  out_psrc1;
    logic [INSTR_COUNT-1:0][PW-1:0]  out_psrc2;
    logic [INSTR_COUNT-1:0][PW-1:0]  out_pdst;
    logic [INSTR_COUNT-1:0]          out_pdst_en;
    logic [INSTR_COUNT-1:0][PW-1:0]  out_old_pdst;

    logic [INSTR_COUNT-1:0]          cm_valid;
    logic [INSTR_COUNT-1:0][LW-1:0]  cm_ldst;
    logic [INSTR_COUNT-1:0][PW-1:0]  cm_pdst;

    // Upstream/environment side: decode, free list, dispatch and commit.
    modport master (
        output flush, in_valid, in_lane_valid, in_src1, in_src2, in_dst, in_dst_en,
               fl_pop_data, fl_valid, out_ready, cm_valid, cm_ldst, cm_pdst,
        input  in_ready, fl_pop, out_valid, out_lane_valid, out_psrc1, out_psrc2,
               out_pdst, out_pdst_en, out_old_pdst
    );

    // Rename stage side.
    modport slave (
        input  flush, in_valid, in_lane_valid, in_src1, in_src2, in_dst, in_dst_en,
               fl_pop_data, fl_valid, out_ready, cm_valid, cm_ldst, cm_pdst,
        output in_ready, fl_pop, out_valid, out_lane_valid, out_psrc1, out_psrc2,
               out_pdst, out_pdst_en, out_old_pdst
    );
endinterface

// File: rtl/rename_map_stage.sv
// Register-rename stage: speculative RAT lookup with intra-bundle bypass,
// one-cycle registered output, retirement RAT copied back on flush.
module rename_map_stage #(
    parameter int L_REGISTERS = 32,
    parameter int P_REGISTERS = 128,
    parameter int INSTR_COUNT = 2,
    parameter int LW          = $clog2(L_REGISTERS),
    parameter int PW          = $clog2(P_REGISTERS)
) (
    input  logic               clk,
    input  logic               rst,
    rename_map_stage_if.slave  bus
);
    logic [PW-1:0] spec_rat_q [L_REGISTERS];
    logic [PW-1:0] spec_rat_d [L_REGISTERS];
    logic [PW-1:0] cmt_rat_q  [L_REGISTERS];
    logic [PW-1:0] cmt_rat_d  [L_REGISTERS];

    logic                           out_valid_q,      out_valid_d;
    logic [INSTR_COUNT-1:0]         out_lane_valid_q, out_lane_valid_d;
    logic [INSTR_COUNT-1:0][PW-1:0] out_psrc1_q,      out_psrc1_d;
    logic [INSTR_COUNT-1:0][PW-1:0] out_psrc2_q,      out_psrc2_d;
    logic [INSTR_COUNT-1:0][PW-1:0] out_pdst_q,       out_pdst_d;
    logic [INSTR_COUNT-1:0]         out_pdst_en_q,    out_pdst_en_d;
    logic [INSTR_COUNT-1:0][PW-1:0] out_old_pdst_q,   out_old_pdst_d;

    logic                           in_ready;
    logic                           fire;
    logic [INSTR_COUNT-1:0]         is_real;
    logic [INSTR_COUNT-1:0][PW-1:0] ren_psrc1;
    logic [INSTR_COUNT-1:0][PW-1:0] ren_psrc2;
    logic [INSTR_COUNT-1:0][PW-1:0] ren_old_pdst;

    // Rst is folded in so nothing is popped while the RATs are being reset.
    assign in_ready     = bus.fl_valid & (~out_valid_q | bus.out_ready) & ~bus.flush & ~rst;
    assign fire         = bus.in_valid & in_ready;
    assign bus.in_ready = in_ready;
    assign bus.fl_pop   = fire;

    // A lane only allocates when present, enabled and not targeting x0.
    always_comb begin
        for (int k = 0; k < INSTR_COUNT; k++) begin
            is_real[k] = bus.in_lane_valid[k] & bus.in_dst_en[k] & (bus.in_dst[k] != '0);
        end
    end

    // Source and old-destination lookup; ascending scan lets the youngest older lane win.
    always_comb begin
        for (int k = 0; k < INSTR_COUNT; k++) begin
            ren_psrc1[k] = (bus.in_src1[k] == '0) ? '0 : spec_rat_q[bus.in_src1[k]];
            ren_psrc2[k] = (bus.in_src2[k] == '0) ? '0 : spec_rat_q[bus.in_src2[k]];
            // A lane without a real destination hands its popped register back at commit.
            ren_old_pdst[k] = is_real[k] ? spec_rat_q[bus.in_dst[k]] : bus.fl_pop_data[k];
            for (int i = 0; i < k; i++) begin
                if (is_real[i] && bus.in_dst[i] == bus.in_src1[k]) begin
                    ren_psrc1[k] = bus.fl_pop_data[i];
                end
                if (is_real[i] && bus.in_dst[i] == bus.in_src2[k]) begin
                    ren_psrc2[k] = bus.fl_pop_data[i];
                end
                if (is_real[i] && is_real[k] && bus.in_dst[i] == bus.in_dst[k]) begin
                    ren_old_pdst[k] = bus.fl_pop_data[i];
                end
            end
        end
    end

    // Retirement RAT update; younger commit lane wins on the same index.
    always_comb begin
        cmt_rat_d = cmt_rat_q;
        for (int k = 0; k < INSTR_COUNT; k++) begin
            if (bus.cm_valid[k] && bus.cm_ldst[k] != '0) begin
                cmt_rat_d[bus.cm_ldst[k]] = bus.cm_pdst[k];
            end
        end
    end

    // Speculative RAT: restore from retirement state (with this cycle's commits) or allocate.
    always_comb begin
        spec_rat_d = spec_rat_q;
        if (bus.flush) begin
            spec_rat_d = cmt_rat_d;
        end else if (fire) begin
            for (int k = 0; k < INSTR_COUNT; k++) begin
                if (is_real[k]) begin
                    spec_rat_d[bus.in_dst[k]] = bus.fl_pop_data[k];
                end
            end
        end
    end

    // Output register: load on fire, drain on out_ready, hold while stalled.
    always_comb begin
        out_valid_d      = out_valid_q;
        out_lane_valid_d = out_lane_valid_q;
        out_psrc1_d      = out_psrc1_q;
        out_psrc2_d      = out_psrc2_q;
        out_pdst_d       = out_pdst_q;
        out_pdst_en_d    = out_pdst_en_q;
        out_old_pdst_d   = out_old_pdst_q;
        if (bus.flush) begin
            out_valid_d = 1'b0;
        end else if (fire) begin
            out_valid_d      = 1'b1;
            out_lane_valid_d = bus.in_lane_valid;
            out_psrc1_d      = ren_psrc1;
            out_psrc2_d      = ren_psrc2;
            out_pdst_d       = bus.fl_pop_data;
            out_pdst_en_d    = is_real;
            out_old_pdst_d   = ren_old_pdst;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers; both RATs reset to the identity mapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < L_REGISTERS; i++) begin
                spec_rat_q[i] <= PW'(i);
                cmt_rat_q[i]  <= PW'(i);
            end
            out_valid_q      <= 1'b0;
            out_lane_valid_q <= '0;
            out_psrc1_q      <= '0;
            out_psrc2_q      <= '0;
            out_pdst_q       <= '0;
            out_pdst_en_q    <= '0;
            out_old_pdst_q   <= '0;
        end else begin
            spec_rat_q       <= spec_rat_d;
            cmt_rat_q        <= cmt_rat_d;
            out_valid_q      <= out_valid_d;
            out_lane_valid_q <= out_lane_valid_d;
            out_psrc1_q      <= out_psrc1_d;
            out_psrc2_q      <= out_psrc2_d;
            out_pdst_q       <= out_pdst_d;
            out_pdst_en_q    <= out_pdst_en_d;
            out_old_pdst_q   <= out_old_pdst_d;
        end
    end

    assign bus.out_valid      = out_valid_q;
    assign bus.out_lane_valid = out_lane_valid_q;
    assign bus.out_psrc1      = out_psrc1_q;
    assign bus.out_psrc2      = out_psrc2_q;
    assign bus.out_pdst       = out_pdst_q;
    assign bus.out_pdst_en    = out_pdst_en_q;
    assign bus.out_old_pdst   = out_old_pdst_q;
endmodule

// File: tb/tb_rename_map_stage.sv
// Directed bench for rename_map_stage: a table of back-to-back bundles with
// hand-computed renames, then stall, free-list-empty and commit/flush sequences.
module tb_rename_map_stage;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    rename_map_stage_if bus ();

    rename_map_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int lv;
        int s1_0, s1_1, s2_0, s2_1, d_0, d_1, den, p_0, p_1;
        int e_s1_0, e_s1_1, e_s2_0, e_s2_1, e_pen, e_old_0, e_old_1;
    } vec_t;

    vec_t vec [5];

    function automatic vec_t mk(int lv, int s1_0, int s1_1, int s2_0, int s2_1,
                                int d_0, int d_1, int den, int p_0, int p_1,
                                int e_s1_0, int e_s1_1, int e_s2_0, int e_s2_1,
                                int e_pen, int e_old_0, int e_old_1);
        vec_t v;
        v.lv = lv; v.s1_0 = s1_0; v.s1_1 = s1_1; v.s2_0 = s2_0; v.s2_1 = s2_1;
        v.d_0 = d_0; v.d_1 = d_1; v.den = den; v.p_0 = p_0; v.p_1 = p_1;
        v.e_s1_0 = e_s1_0; v.e_s1_1 = e_s1_1; v.e_s2_0 = e_s2_0; v.e_s2_1 = e_s2_1;
        v.e_pen = e_pen; v.e_old_0 = e_old_0; v.e_old_1 = e_old_1;
        return v;
    endfunction

    function automatic logic [31:0] pk(int lane0, int lane1);
        return {18'd0, 7'(lane1), 7'(lane0)};
    endfunction

    // Retirement map after the commit/flush sequence below.
    function automatic int emap(int r);
        if (r == 5)  return 32;
        if (r == 13) return 102;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic drive(input int lv, input int s1_0, input int s1_1, input int s2_0,
                         input int s2_1, input int d_0, input int d_1, input int den,
                         input int p_0, input int p_1);
        bus.in_lane_valid  = 2'(lv);
        bus.in_src1[0]     = 5'(s1_0);
        bus.in_src1[1]     = 5'(s1_1);
        bus.in_src2[0]     = 5'(s2_0);
        bus.in_src2[1]     = 5'(s2_1);
        bus.in_dst[0]      = 5'(d_0);
        bus.in_dst[1]      = 5'(d_1);
        bus.in_dst_en      = 2'(den);
        bus.fl_pop_data[0] = 7'(p_0);
        bus.fl_pop_data[1] = 7'(p_1);
    endtask

    task automatic check_out(input string tag, input int lv, input int s1_0, input int s1_1,
                             input int s2_0, input int s2_1, input int pen,
                             input int pd_0, input int pd_1, input int o_0, input int o_1);
        chk({tag, "_out_valid"},  32'(bus.out_valid),      32'd1);
        chk({tag, "_lane_valid"}, 32'(bus.out_lane_valid), 32'(lv));
        chk({tag, "_psrc1"},      32'(bus.out_psrc1),      pk(s1_0, s1_1));
        chk({tag, "_psrc2"},      32'(bus.out_psrc2),      pk(s2_0, s2_1));
        chk({tag, "_pdst"},       32'(bus.out_pdst),       pk(pd_0, pd_1));
        chk({tag, "_pdst_en"},    32'(bus.out_pdst_en),    32'(pen));
        chk({tag, "_old_pdst"},   32'(bus.out_old_pdst),   pk(o_0, o_1));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.flush = 1'b0; bus.in_valid = 1'b0; bus.fl_valid = 1'b0; bus.out_ready = 1'b0;
        bus.cm_valid = '0; bus.cm_ldst = '0; bus.cm_pdst = '0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        vec[0] = mk(3, 5, 5,  0, 6,  5, 6, 3, 32, 33, 32'd5, 32, 0, 6,  3, 5, 6);
        vec[1] = mk(3, 5, 7,  6, 6,  7, 7, 3, 40, 41, 32, 40, 33, 33, 3, 7, 40);
        vec[2] = mk(3, 7, 7,  0, 9,  9, 0, 2, 50, 51, 41, 41, 0, 9,   0, 50, 51);
        vec[3] = mk(2, 0, 7,  0, 5,  7, 9, 3, 60, 61, 0, 41, 0, 32,   2, 60, 9);
        vec[4] = mk(3, 1, 9, 31, 7,  0, 0, 0, 70, 71, 1, 61, 31, 41,  0, 70, 71);

        // Reset: nothing accepted or popped while rst is high.
        #12;
        bus.in_valid = 1'b1; bus.fl_valid = 1'b1; bus.out_ready = 1'b1;
        #1;
        chk("rst_in_ready",  32'(bus.in_ready),     32'd0);
        chk("rst_fl_pop",    32'(bus.fl_pop),       32'd0);
        chk("rst_out_valid", 32'(bus.out_valid),    32'd0);
        chk("rst_out_pdst",  32'(bus.out_pdst),     32'd0);
        chk("rst_old_pdst",  32'(bus.out_old_pdst), 32'd0);
        bus.in_valid = 1'b0;
        rst = 1'b0;
        step();

        // Back-to-back bundles from the table.
        for (int v = 0; v < 5; v++) begin
            drive(vec[v].lv, vec[v].s1_0, vec[v].s1_1, vec[v].s2_0, vec[v].s2_1,
                  vec[v].d_0, vec[v].d_1, vec[v].den, vec[v].p_0, vec[v].p_1);
            bus.in_valid = 1'b1;
            #1;
            chk($sformatf("v%0d_fl_pop", v), 32'(bus.fl_pop), 32'd1);
            step();
            check_out($sformatf("v%0d", v), vec[v].lv, vec[v].e_s1_0, vec[v].e_s1_1,
                      vec[v].e_s2_0, vec[v].e_s2_1, vec[v].e_pen, vec[v].p_0, vec[v].p_1,
                      vec[v].e_old_0, vec[v].e_old_1);
        end

        // Output stall: hold B1 for three cycles, then transfer and accept B2.
        drive(3, 5, 7, 6, 9, 0, 0, 0, 72, 73);
        step();
        check_out("b1", 3, 32, 41, 33, 61, 0, 72, 73, 72, 73);
        bus.out_ready = 1'b0;
        drive(3, 10, 10, 0, 5, 10, 3, 1, 80, 81);
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("stall%0d_in_ready", c),  32'(bus.in_ready),  32'd0);
            chk($sformatf("stall%0d_fl_pop", c),    32'(bus.fl_pop),    32'd0);
            chk($sformatf("stall%0d_out_valid", c), 32'(bus.out_valid), 32'd1);
            chk($sformatf("stall%0d_psrc1", c),     32'(bus.out_psrc1), pk(32, 41));
            step();
        end
        bus.out_ready = 1'b1;
        #1;
        chk("release_in_ready", 32'(bus.in_ready), 32'd1);
        chk("release_fl_pop",   32'(bus.fl_pop),   32'd1);
        step();
        check_out("b2", 3, 10, 80, 0, 32, 1, 80, 81, 10, 81);

        // Free list empty: no fire until fl_valid returns.
        bus.fl_valid = 1'b0;
        drive(3, 11, 11, 10, 3, 11, 12, 1, 90, 91);
        #1;
        chk("flv0_in_ready", 32'(bus.in_ready), 32'd0);
        chk("flv0_fl_pop",   32'(bus.fl_pop),   32'd0);
        step();
        chk("flv0_out_valid", 32'(bus.out_valid), 32'd0);
        chk("flv0_in_ready2", 32'(bus.in_ready),  32'd0);
        step();
        bus.fl_valid = 1'b1;
        #1;
        chk("flv1_fl_pop", 32'(bus.fl_pop), 32'd1);
        step();
        check_out("c", 3, 11, 90, 80, 3, 1, 90, 91, 11, 91);

        // Commit 5->32 (x0 commit ignored), then flush with same-cycle commits to 13.
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.cm_valid = 2'b11;
        bus.cm_ldst[0] = 5'd5;  bus.cm_pdst[0] = 7'd32;
        bus.cm_ldst[1] = 5'd0;  bus.cm_pdst[1] = 7'd99;
        step();
        bus.flush = 1'b1;
        bus.in_valid = 1'b1;
        drive(3, 5, 6, 5, 6, 5, 6, 3, 120, 121);
        bus.cm_ldst[0] = 5'd13; bus.cm_pdst[0] = 7'd101;
        bus.cm_ldst[1] = 5'd13; bus.cm_pdst[1] = 7'd102;
        #1;
        chk("flush_in_ready",      32'(bus.in_ready),  32'd0);
        chk("flush_fl_pop",        32'(bus.fl_pop),    32'd0);
        chk("preflush_out_valid",  32'(bus.out_valid), 32'd1);
        step();
        bus.flush = 1'b0;
        bus.cm_valid = '0;
        chk("postflush_out_valid", 32'(bus.out_valid), 32'd0);

        // Sweep all architectural registers through the restored map.
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(3, 4*i, 4*i+2, 4*i+1, 4*i+3, 0, 0, 0, 110, 111);
            step();
            chk($sformatf("sweep%0d_psrc1", i), 32'(bus.out_psrc1),
                pk(emap(4*i), emap(4*i+2)));
            chk($sformatf("sweep%0d_psrc2", i), 32'(bus.out_psrc2),
                pk(emap(4*i+1), emap(4*i+3)));
            chk($sformatf("sweep%0d_pdst_en", i), 32'(bus.out_pdst_en), 32'd0);
        end
        bus.in_valid = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/rename_map_stage.md
Name: rename_map_stage

Overview:
- Register-rename stage for the superscalar front end. Accepts a bundle of INSTR_COUNT decoded instructions per cycle and pops INSTR_COUNT physical registers from the free list.
- Renames sources and destinations through a speculative alias table (RAT) and emits a registered, renamed bundle to dispatch/ROB.
- Maintains a committed (retirement) RAT, which is copied into the speculative RAT on flush.

Parameters:
- L_REGISTERS, 32: number of architectural registers; register 0 is hard-wired zero.
- P_REGISTERS, 128: number of physical registers.
- INSTR_COUNT, 2: lanes per bundle; only 2 is verified.
- LW, $clog2(L_REGISTERS): width of an architectural register index.
- PW, $clog2(P_REGISTERS): width of a physical register index.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- flush  in  1  pipeline flush (mispredict/exception)
- in_valid  in  1  decode bundle valid
- in_ready  out  1  bundle accepted when in_valid & in_ready
- in_lane_valid  in  [INSTR_COUNT]  per-lane instruction present
- in_src1, in_src2  in  [INSTR_COUNT][LW]  architectural sources
- in_dst  in  [INSTR_COUNT][LW]  architectural destination
- in_dst_en  in  [INSTR_COUNT]  lane writes a destination
- fl_pop_data  in  [INSTR_COUNT][PW]  free physical registers offered by the free list
- fl_valid  in  1  free list holds at least INSTR_COUNT entries
- fl_pop  out  1  consume all INSTR_COUNT offered registers
- out_valid  out  1  renamed bundle valid
- out_ready  in  1  dispatch accepts the bundle
- out_lane_valid  out  [INSTR_COUNT]  registered copy of in_lane_valid
- out_psrc1, out_psrc2  out  [INSTR_COUNT][PW]  physical sources
- out_pdst  out  [INSTR_COUNT][PW]  new physical destination
- out_pdst_en  out  [INSTR_COUNT]  lane has a real destination
- out_old_pdst  out  [INSTR_COUNT][PW]  register to release at commit of this lane
- cm_valid  in  [INSTR_COUNT]  commit of a lane with a destination
- cm_ldst  in  [INSTR_COUNT][LW]  committed architectural destination
- cm_pdst  in  [INSTR_COUNT][PW]  committed physical destination

Behaviour:
- Reset:
  - spec_rat[i] = i and cmt_rat[i] = i for all i.
  - out_valid = 0; all other out_* = 0.
  - in_ready = 0 and fl_pop = 0 while rst is asserted.
- Handshake:
  - in_ready = fl_valid & (~out_valid | out_ready) & ~flush.
  - fire = in_valid & in_ready.
  - fl_pop = fire, combinational; exactly one pop of INSTR_COUNT registers per fired bundle.
- Latency:
  - One cycle; outputs are registered.
  - On fire, out_* load and out_valid <= 1.
  - Otherwise, if out_ready, out_valid <= 0.
  - Outputs hold stable while out_valid & ~out_ready.
- Real destination: real[k] = in_lane_valid[k] & in_dst_en[k] & (in_dst[k] != 0).
- Lane k with real[k]:
  - out_pdst[k] = fl_pop_data[k], out_pdst_en[k] = 1.
  - out_old_pdst[k] = prior mapping of in_dst[k].
- Lane k without real[k]:
  - out_pdst_en[k] = 0, out_pdst[k] = fl_pop_data[k].
  - out_old_pdst[k] = fl_pop_data[k], so the unused register is returned at commit (no leak).
- Source lookup:
  - psrc = spec_rat[src], read before this bundle's writes.
  - Intra-bundle bypass: a lane-j source equal to in_dst[i] of an older lane i<j with real[i] takes fl_pop_data[i]; the youngest such older lane wins.
  - Source 0 always maps to 0.
- Old-destination bypass: for lane j, out_old_pdst[j] takes fl_pop_data[i] of the youngest older real lane i with in_dst[i] == in_dst[j].
- spec_rat write on fire: spec_rat[in_dst[k]] <= fl_pop_data[k] for each real lane. Younger lane wins on a same-index conflict. Index 0 is never written.
- Commit: each cycle, for each cm_valid[k] with cm_ldst[k] != 0, cmt_rat[cm_ldst[k]] <= cm_pdst[k]. Younger lane wins on conflict. Commits are independent of the in/out handshake.
- Flush:
  - spec_rat <= cmt_rat, including commits presented in the same cycle.
  - out_valid <= 0; no fire that cycle.
  - Flush overrides rst-free activity; rst overrides everything.
- Free-list recovery on flush is outside this block.
- Back-pressure: fl_valid = 0 or a stalled output gives in_ready = 0; spec_rat and fl_pop are unchanged.

Test Plan:
- After reset: bundle lane0 {dst=5, src1=5}, lane1 {dst=6, src1=5}, fl_pop_data={32,33} -> next cycle: lane0 psrc1=5, pdst=32, old_pdst=5; lane1 psrc1=32 (bypass), pdst=33, old_pdst=6; fl_pop pulsed for 1 cycle.
- Same-destination bundle: both lanes dst=7, pops {40,41} -> lane1 old_pdst=40, lane0 old_pdst=7. A subsequent src=7 reads 41.
- Lane0 dst_en=0 and lane1 dst=0, pops {50,51} -> pdst_en=00, old_pdst={50,51}; spec_rat unchanged; reading regs 0..31 returns identity.
- out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, fl_pop=0, outputs stable; on release, one transfer then accept of the next bundle.
- fl_valid=0 with in_valid=1 -> no fire and no RAT change; fire resumes the cycle fl_valid=1.
- Rename 5->32 and 6->33, commit only {5,32}, then flush -> next bundle src 5 reads 32, src 6 reads 6, out_valid dropped in the flush cycle.
